// File: rtl/cache_nway_pkg.sv
// Shared types and helpers for the N-way set-associative write-back cache.
package cache_nway_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WB     = 3'd1,
        ST_REQ    = 3'd2,
        ST_FILL   = 3'd3,
        ST_REPLAY = 3'd4
    } cache_state_t;

    // Merge a store into an existing word, one byte lane per mask bit.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  mask);
        logic [31:0] result;
        for (int b = 0; b < 4; b++) begin
            result[b*8 +: 8] = mask[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/cache_way.sv
// One way of the cache: tag/valid/dirty/data arrays with combinational lookup,
// byte-masked store write and whole-line fill write.
import cache_nway_pkg::*;

module cache_way #(
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 16,
    parameter int TAG_W      = 22,
    localparam int IDX_W     = $clog2(SETS),
    localparam int OFF_W     = $clog2(LINE_WORDS),
    localparam int LW        = LINE_WORDS * 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  idx,
    input  logic [TAG_W-1:0]  tag,
    input  logic [OFF_W-1:0]  word_sel,
    input  logic              store_en,
    input  logic [3:0]        store_mask,
    input  logic [31:0]       store_data,
    input  logic              fill_en,
    input  logic [LW-1:0]     fill_line,
    output logic              hit,
    output logic [31:0]       word,
    output logic              valid,
    output logic              dirty,
    output logic [TAG_W-1:0]  tag_out,
    output logic [LW-1:0]     line
);

    logic [SETS-1:0]  valid_bits;
    logic [SETS-1:0]  dirty_bits;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [LW-1:0]    data_mem [SETS];

    // Valid/dirty state is reset; a fill makes the line clean, a store dirties it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (fill_en) begin
            valid_bits[idx] <= 1'b1;
            dirty_bits[idx] <= 1'b0;
        end else if (store_en) begin
            dirty_bits[idx] <= 1'b1;
        end
    end

    // Tag and data storage are plain memories with no reset.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= fill_line;
        end else if (store_en) begin
            data_mem[idx][{word_sel, 5'b0} +: 32] <= merge_bytes(word, store_data, store_mask);
        end
    end

    // Combinational lookup of the addressed set.
    always_comb begin
        valid   = valid_bits[idx];
        dirty   = dirty_bits[idx];
        tag_out = tag_mem[idx];
        line    = data_mem[idx];
        word    = line[{word_sel, 5'b0} +: 32];
        hit     = valid && (tag_out == tag);
    end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-back, write-allocate cache for the MEM stage.
// Miss sequencing: dirty victim write-back, refill request, fill, replay.
// Optional macro CACHE_PERF_EN adds hit_cnt/miss_cnt performance counters.
import cache_nway_pkg::*;

module cache_nway #(
    parameter int WAYS       = 4,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 16,
    localparam int LW        = LINE_WORDS * 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [3:0]    wen,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          stallreq,
    output logic          wen_back,
    output logic [31:0]   waddr,
    output logic [LW-1:0] wback,
    input  logic          fin,
    output logic          miss,
    output logic [31:0]   miss_addr,
    input  logic          accept,
    input  logic          wen_fill,
    input  logic [LW-1:0] wfill
`ifdef CACHE_PERF_EN
    ,
    output logic [31:0]   hit_cnt,
    output logic [31:0]   miss_cnt
`endif
);

    localparam int OFF = $clog2(LINE_WORDS);
    localparam int IDX = $clog2(SETS);
    localparam int TW  = 32 - OFF - IDX - 2;
    localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1;

    cache_state_t state, state_next;

    logic [IDX-1:0] addr_idx, lat_idx, look_idx;
    logic [TW-1:0]  addr_tag, lat_tag, look_tag;
    logic [OFF-1:0] addr_word;
    logic [WW-1:0]  victim, victim_q;
    logic [WW-1:0]  rr [SETS];
    logic           victim_dirty;
    logic           hit, serve, start_miss;
    logic [31:0]    hit_word;
    logic [1:0]     unused_addr_bits;

    logic [WAYS-1:0] way_hit, way_valid, way_dirty, store_en, fill_en;
    logic [31:0]     way_word [WAYS];
    logic [TW-1:0]   way_tag  [WAYS];
    logic [LW-1:0]   way_line [WAYS];

    assign addr_idx         = addr[OFF+2 +: IDX];
    assign addr_tag         = addr[31 -: TW];
    assign addr_word        = addr[2 +: OFF];
    assign unused_addr_bits = addr[1:0];

    // Lookups follow the live address when serving, the latched miss otherwise.
    always_comb begin
        if (state == ST_IDLE || state == ST_REPLAY) begin
            look_idx = addr_idx;
            look_tag = addr_tag;
        end else begin
            look_idx = lat_idx;
            look_tag = lat_tag;
        end
    end

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        cache_way #(
            .SETS(SETS),
            .LINE_WORDS(LINE_WORDS),
            .TAG_W(TW)
        ) u_way (
            .clk(clk),
            .rst(rst),
            .idx(look_idx),
            .tag(look_tag),
            .word_sel(addr_word),
            .store_en(store_en[g]),
            .store_mask(wen),
            .store_data(wdata),
            .fill_en(fill_en[g]),
            .fill_line(wfill),
            .hit(way_hit[g]),
            .word(way_word[g]),
            .valid(way_valid[g]),
            .dirty(way_dirty[g]),
            .tag_out(way_tag[g]),
            .line(way_line[g])
        );
    end

    // Hit detection, read-word mux, and per-way write strobes.
    always_comb begin
        hit_word = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (way_hit[i]) hit_word = hit_word | way_word[i];
        end
        hit        = |way_hit;
        serve      = en && hit && (state == ST_IDLE || state == ST_REPLAY);
        stallreq   = en && !serve;
        start_miss = en && !hit && (state == ST_IDLE);
        for (int i = 0; i < WAYS; i++) begin
            store_en[i] = serve && (wen != 4'b0000) && way_hit[i];
            fill_en[i]  = (state == ST_FILL) && wen_fill && (victim_q == WW'(i));
        end
    end

    // Victim choice: lowest-index invalid way, otherwise the set's round-robin pointer.
    always_comb begin
        victim = rr[addr_idx];
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!way_valid[i]) victim = WW'(i);
        end
        victim_dirty = way_valid[victim] && way_dirty[victim];
    end

    // Miss FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Miss FSM next-state and handshake outputs.
    always_comb begin
        state_next = state;
        wen_back   = 1'b0;
        miss       = 1'b0;
        unique case (state)
            ST_IDLE:   if (start_miss) state_next = victim_dirty ? ST_WB : ST_REQ;
            ST_WB: begin
                wen_back = 1'b1;
                if (fin) state_next = ST_REQ;
            end
            ST_REQ: begin
                miss = 1'b1;
                if (accept) state_next = ST_FILL;
            end
            ST_FILL:   if (wen_fill) state_next = ST_REPLAY;
            ST_REPLAY: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Latch the missing access, its victim and the write-back payload at miss start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_idx   <= '0;
            lat_tag   <= '0;
            victim_q  <= '0;
            miss_addr <= '0;
            waddr     <= '0;
            wback     <= '0;
        end else if (start_miss) begin
            lat_idx   <= addr_idx;
            lat_tag   <= addr_tag;
            victim_q  <= victim;
            miss_addr <= {addr[31:OFF+2], {(OFF + 2){1'b0}}};
            if (victim_dirty) begin
                waddr <= {way_tag[victim], addr_idx, {(OFF + 2){1'b0}}};
                wback <= way_line[victim];
            end
        end
    end

    // Round-robin pointer advances once per completed fill of its set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) rr[s] <= '0;
        end else if (state == ST_FILL && wen_fill) begin
            rr[lat_idx] <= (rr[lat_idx] == WW'(WAYS - 1)) ? '0 : rr[lat_idx] + WW'(1);
        end
    end

    // Registered load data; a served store returns zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rdata <= '0;
        else if (serve) rdata <= (wen == 4'b0000) ? hit_word : 32'h0;
    end

`ifdef CACHE_PERF_EN
    // Performance counters: IDLE hit cycles and miss starts, wrapping at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (en && hit && state == ST_IDLE) hit_cnt <= hit_cnt + 32'd1;
            if (start_miss)                    miss_cnt <= miss_cnt + 32'd1;
        end
    end
`else
    // Built without performance counters.
`endif

endmodule

// File: tb/tb_cache_nway.sv
// Directed self-checking bench for cache_nway (WAYS=4, SETS=16, LINE_WORDS=16).
module tb_cache_nway;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [3:0]   wen = 4'b0;
    logic [31:0]  addr = 32'h0;
    logic [31:0]  wdata = 32'h0;
    logic [31:0]  rdata;
    logic         stallreq;
    logic         wen_back;
    logic [31:0]  waddr;
    logic [511:0] wback;
    logic         fin = 1'b0;
    logic         miss;
    logic [31:0]  miss_addr;
    logic         accept = 1'b0;
    logic         wen_fill = 1'b0;
    logic [511:0] wfill = '0;
`ifdef CACHE_PERF_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    int total_checks = 0;
    int passed_checks = 0;

    cache_nway dut (
        .clk(clk), .rst(rst), .en(en), .wen(wen), .addr(addr), .wdata(wdata),
        .rdata(rdata), .stallreq(stallreq), .wen_back(wen_back), .waddr(waddr),
        .wback(wback), .fin(fin), .miss(miss), .miss_addr(miss_addr),
        .accept(accept), .wen_fill(wen_fill), .wfill(wfill)
`ifdef CACHE_PERF_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got === exp) passed_checks++;
        else $display("[TB] FAIL %s: observed %h, expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic e, input logic [31:0] a,
                                 input logic [3:0] m, input logic [31:0] d);
        en = e; addr = a; wen = m; wdata = d;
        #1;
    endtask

    function automatic logic [511:0] mkline(input logic [31:0] base);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = base + 32'(k);
        return l;
    endfunction

    // Drives the line-engine side of one miss from IDLE through REPLAY into IDLE.
    task automatic serveMiss(input logic [511:0] line, input bit do_wb, input int fin_delay,
                             input logic [31:0] exp_waddr, input logic [31:0] exp_w0,
                             input logic [31:0] exp_w2, input logic [31:0] exp_maddr,
                             input bit drop_en);
        checkOutput("miss_stall", {31'b0, stallreq}, 32'd1);
        tick();
        if (do_wb) begin
            checkOutput("wb_req", {31'b0, wen_back}, 32'd1);
            checkOutput("waddr", waddr, exp_waddr);
            checkOutput("wback_w0", wback[31:0], exp_w0);
            checkOutput("wback_w2", wback[95:64], exp_w2);
            for (int c = 0; c < fin_delay; c++) begin
                checkOutput("miss_before_fin", {31'b0, miss}, 32'd0);
                checkOutput("stall_in_wb", {31'b0, stallreq}, 32'd1);
                tick();
            end
            fin = 1'b1;
            #1;
            checkOutput("miss_at_fin", {31'b0, miss}, 32'd0);
            tick();
            fin = 1'b0;
        end else begin
            checkOutput("no_wb", {31'b0, wen_back}, 32'd0);
        end
        checkOutput("miss_req", {31'b0, miss}, 32'd1);
        checkOutput("miss_addr", miss_addr, exp_maddr);
        if (drop_en) begin
            applyStimulus(1'b0, addr, wen, wdata);
            checkOutput("stall_en_low", {31'b0, stallreq}, 32'd0);
        end
        accept = 1'b1;
        tick();
        accept = 1'b0;
        #1;
        checkOutput("miss_drop", {31'b0, miss}, 32'd0);
        wfill = line;
        wen_fill = 1'b1;
        tick();
        wen_fill = 1'b0;
        checkOutput("replay_stall", {31'b0, stallreq}, 32'd0);
        tick();
    endtask

    initial begin
        logic [511:0] l1;
        logic [511:0] lx;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("rst_rdata", rdata, 32'h0);
        checkOutput("rst_stall", {31'b0, stallreq}, 32'd0);
        checkOutput("rst_wen_back", {31'b0, wen_back}, 32'd0);
        checkOutput("rst_miss", {31'b0, miss}, 32'd0);
        checkOutput("rst_miss_addr", miss_addr, 32'h0);
        checkOutput("rst_waddr", waddr, 32'h0);
        tick();

        $display("[TB] cold load miss and refill");
        l1 = mkline(32'h1000_0000);
        l1[31:0]  = 32'hDEAD_BEEF;
        l1[95:64] = 32'h1122_3344;
        applyStimulus(1'b1, 32'h0000_1000, 4'b0000, 32'h0);
        serveMiss(l1, 1'b0, 0, 32'h0, 32'h0, 32'h0, 32'h0000_1000, 1'b0);
        checkOutput("cold_rdata", rdata, 32'hDEAD_BEEF);
        checkOutput("repeat_hit_stall", {31'b0, stallreq}, 32'd0);
        tick();
        checkOutput("repeat_rdata", rdata, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 32'h0000_1004, 4'b0000, 32'h0);
        tick();
        checkOutput("word1_rdata", rdata, 32'h1000_0001);

        $display("[TB] byte-masked store");
        applyStimulus(1'b1, 32'h0000_1008, 4'b0101, 32'hAABB_CCDD);
        checkOutput("store_stall", {31'b0, stallreq}, 32'd0);
        tick();
        checkOutput("store_rdata", rdata, 32'h0);
        applyStimulus(1'b1, 32'h0000_1008, 4'b0000, 32'h0);
        tick();
        checkOutput("merged_word", rdata, 32'h11BB_33DD);

        $display("[TB] fill one set and evict");
        for (int n = 1; n <= 3; n++) begin
            logic [31:0] a;
            a = 32'h0000_1000 + 32'(n) * 32'h400;
            applyStimulus(1'b1, a, 4'b0000, 32'h0);
            serveMiss(mkline(a << 16), 1'b0, 0, 32'h0, 32'h0, 32'h0, a, 1'b0);
            checkOutput("set_fill_rdata", rdata, a << 16);
        end
        applyStimulus(1'b1, 32'h0000_2000, 4'b0000, 32'h0);
        serveMiss(mkline(32'h2000_0000), 1'b1, 10, 32'h0000_1000,
                  32'hDEAD_BEEF, 32'h11BB_33DD, 32'h0000_2000, 1'b0);
        checkOutput("evict_rdata", rdata, 32'h2000_0000);
        lx = mkline(32'h3000_0000);
        lx[31:0] = 32'h0BAD_F00D;
        applyStimulus(1'b1, 32'h0000_1000, 4'b0000, 32'h0);
        serveMiss(lx, 1'b0, 0, 32'h0, 32'h0, 32'h0, 32'h0000_1000, 1'b0);
        checkOutput("reload_rdata", rdata, 32'h0BAD_F00D);
        applyStimulus(1'b1, 32'h0000_2000, 4'b0000, 32'h0);
        checkOutput("kept_line_hit", {31'b0, stallreq}, 32'd0);
        tick();
        checkOutput("kept_line_rdata", rdata, 32'h2000_0000);
        applyStimulus(1'b1, 32'h0000_1400, 4'b0000, 32'h0);
        checkOutput("evicted_way1_miss", {31'b0, stallreq}, 32'd1);
        applyStimulus(1'b0, 32'h0000_1400, 4'b0000, 32'h0);
        checkOutput("idle_en_low_stall", {31'b0, stallreq}, 32'd0);
        tick();

        $display("[TB] reset during fill");
        applyStimulus(1'b1, 32'h0000_4040, 4'b0000, 32'h0);
        checkOutput("r_miss_stall", {31'b0, stallreq}, 32'd1);
        tick();
        checkOutput("r_miss_req", {31'b0, miss}, 32'd1);
        accept = 1'b1;
        tick();
        accept = 1'b0;
        rst = 1'b1;
        en = 1'b0;
        #1;
        checkOutput("r_rdata", rdata, 32'h0);
        checkOutput("r_miss", {31'b0, miss}, 32'd0);
        checkOutput("r_wen_back", {31'b0, wen_back}, 32'd0);
        checkOutput("r_miss_addr", miss_addr, 32'h0);
        checkOutput("r_waddr", waddr, 32'h0);
        checkOutput("r_stall", {31'b0, stallreq}, 32'd0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b1, 32'h0000_4040, 4'b0000, 32'h0);
        serveMiss(mkline(32'h4040_0000), 1'b0, 0, 32'h0, 32'h0, 32'h0, 32'h0000_4040, 1'b0);
        checkOutput("r_refill_rdata", rdata, 32'h4040_0000);

        $display("[TB] en dropped during refill request");
        applyStimulus(1'b1, 32'h0000_5080, 4'b1111, 32'hCAFE_F00D);
        serveMiss(mkline(32'h5000_0000), 1'b0, 0, 32'h0, 32'h0, 32'h0, 32'h0000_5080, 1'b1);
        applyStimulus(1'b1, 32'h0000_5080, 4'b0000, 32'h0);
        checkOutput("drop_line_valid", {31'b0, stallreq}, 32'd0);
        tick();
        checkOutput("drop_no_store", rdata, 32'h5000_0000);

        $display("[TB] %0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
